// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader slice.
//
// Contents:
//   BYTES_PER_WORD - stream bytes packed into one instruction word
//   CNT_W          - width of the word count sent at the head of the image
//   bootState_e    - loader FSM state encoding
//   countOversize  - true when a received word count exceeds the memory depth
package boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } bootState_e;

  // The image may fill memory exactly, so only a count strictly larger than
  // the depth is rejected.
  function automatic logic countOversize(input logic [CNT_W-1:0] count,
                                         input int unsigned depth);
    return 32'(count) > depth;
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler for the boot loader.
//
// Collects accepted stream bytes into a 32-bit little-endian word: the first
// byte of a group lands in bits [7:0], the fourth in bits [31:24].
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset; discards a partial word
//   byteAccept_i - a data byte is being accepted this cycle
//   byteData_i   - the byte being accepted
//   word_o       - assembled word, meaningful when wordValid_o is high
//   wordValid_o  - high in the cycle the fourth byte of a word is accepted
module boot_word_asm
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byteAccept_i,
  input  logic [7:0]  byteData_i,
  output logic [31:0] word_o,
  output logic        wordValid_o
);

  logic [1:0]  byteCnt_q;
  logic [23:0] shift_q;

  // The fourth byte is taken straight from the input rather than waiting a
  // cycle for it to be shifted in, so the owner can register the full word
  // on the same edge that accepts the last byte.
  assign word_o      = {byteData_i, shift_q};
  assign wordValid_o = byteAccept_i && (byteCnt_q == 2'(BYTES_PER_WORD - 1));

  // Older bytes move toward bit 0 as new ones arrive, which yields the
  // little-endian ordering once three bytes are held. The counter wraps
  // naturally after the fourth byte, so the next word starts cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt_q <= '0;
      shift_q   <= '0;
    end else if (byteAccept_i) begin
      byteCnt_q <= byteCnt_q + 2'd1;
      shift_q   <= {byteData_i, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a program image as a byte stream and writes it into
// instruction memory, holding the CPU in reset until the image is loaded.
//
// Stream: count_lo, count_hi (word count N), N*4 little-endian data bytes,
// then one XOR checksum byte when BOOT_CHECKSUM_EN is defined.
//
// Configuration macro:
//   BOOT_CHECKSUM_EN - adds the CSUM state and XOR checksum check. When
//                      undefined, the last data word (or N == 0) goes
//                      straight to DONE and err only flags an oversize count.
//
// Parameters:
//   ADDR_W - instruction memory word-address width (depth 2**ADDR_W)
//   WORD_W - instruction word width, fixed at 32
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   byte_valid - upstream presents byte_data
//   byte_data  - stream byte
//   byte_ready - loader accepts a byte this cycle (decode of state and reset)
//   imem_we    - one-cycle instruction memory write strobe
//   imem_addr  - word address of the write
//   imem_wdata - word to write
//   cpu_reset  - CPU core reset, high until the load has succeeded
//   done       - image loaded successfully (sticky)
//   err        - load failed (sticky until reset)
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  bootState_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] wordIdx_q;
  logic              imemWe_q;
  logic [ADDR_W-1:0] imemAddr_q;
  logic [WORD_W-1:0] imemWdata_q;
  logic              cpuReset_q;
  logic              done_q;
  logic              err_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              accept;
  logic [CNT_W-1:0]  count_d;
  logic              oversize;
  logic              lastWord;
  logic              asmValid;
  logic [31:0]       asmWord;

  // Ready is a pure decode so a byte is accepted in the very cycle the loader
  // enters a receiving state; reset forces it low immediately.
  assign byte_ready = !reset && (state_q inside {CNT_LO, CNT_HI, DATA, CSUM});
  assign accept     = byte_valid && byte_ready;

  // The full count is only known when count_hi arrives, so the range check
  // is done on the combined value before it is registered.
  assign count_d  = {byte_data, count_q[7:0]};
  assign oversize = countOversize(count_d, DEPTH);

  // The index of the last word is N-1; count_q holds N throughout DATA.
  assign lastWord = (CNT_W'(wordIdx_q) == (count_q - CNT_W'(1)));

  boot_word_asm u_word_asm (
    .clk          (clk),
    .reset        (reset),
    .byteAccept_i (accept && (state_q == DATA)),
    .byteData_i   (byte_data),
    .word_o       (asmWord),
    .wordValid_o  (asmValid)
  );

  // Loader FSM with all outputs registered alongside the state. Entering DONE
  // or ERR updates done/err/cpu_reset on the same edge that accepts the final
  // byte, so they change in the following cycle. The write strobe defaults
  // low every cycle so it only ever lasts one cycle. The word index is not
  // advanced past the last word, so a full-depth image never wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CNT_LO;
      count_q     <= '0;
      wordIdx_q   <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuReset_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      imemWe_q <= 1'b0;
      case (state_q)
        CNT_LO: begin
          if (accept) begin
            count_q[7:0] <= byte_data;
            state_q      <= CNT_HI;
          end
        end

        CNT_HI: begin
          if (accept) begin
            count_q <= count_d;
            if (oversize) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (count_d == '0) begin
`ifdef BOOT_CHECKSUM_EN
              state_q    <= CSUM;
`else
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpuReset_q <= 1'b0;
`endif
            end else begin
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
            if (asmValid) begin
              imemWe_q    <= 1'b1;
              imemAddr_q  <= wordIdx_q;
              imemWdata_q <= asmWord;
              if (lastWord) begin
`ifdef BOOT_CHECKSUM_EN
                state_q    <= CSUM;
`else
                state_q    <= DONE;
                done_q     <= 1'b1;
                cpuReset_q <= 1'b0;
`endif
              end else begin
                wordIdx_q <= wordIdx_q + ADDR_W'(1);
              end
            end
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (byte_data == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpuReset_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          state_q <= DONE;
        end

        ERR: begin
          state_q <= ERR;
        end

        // Only reachable through a corrupted state register; fail safe with
        // the CPU still held in reset.
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_we    = imemWe_q;
  assign imem_addr  = imemAddr_q;
  assign imem_wdata = imemWdata_q;
  assign cpu_reset  = cpuReset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader. Stimulus pushes each expected memory write into
// a scoreboard queue; a monitor pops and compares on every write strobe.
module tb_boot_loader;

  localparam int ADDR_W = 6;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  int   total = 0;
  int   bad   = 0;
  wr_t  sbq[$];
  logic [31:0] imageWords[$];

  boot_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait somehow never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    wr_t expWr;
    if (imem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected write: addr=0x%0h data=0x%0h, expected no write", imem_addr, imem_wdata);
      end else begin
        expWr = sbq.pop_front();
        checkOutput("imem_addr", 32'(imem_addr), 32'(expWr.addr));
        checkOutput("imem_wdata", imem_wdata, expWr.data);
      end
    end
  end

  // Present one byte, optionally after idle cycles, and hold it until accepted.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    int waitCycles = 0;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ok && waitCycles < 20) begin
      @(negedge clk);
      if (byte_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    byte_valid = 1'b0;
    if (!ok) checkOutput("byte accept", 32'(ok), 32'd1);
  endtask

  // Send a full image from imageWords with count n, queueing expected writes.
  task automatic applyStimulus(input int n, input int gapMax, input bit flipCsum);
    logic [7:0] csum = 8'h00;
    logic [31:0] w;
    logic [7:0] b;
    logic [15:0] n16 = 16'(n);
    sendByte(n16[7:0], 0);
    sendByte(n16[15:8], 0);
    for (int i = 0; i < imageWords.size(); i++) begin
      w = imageWords[i];
      sbq.push_back('{addr: ADDR_W'(i), data: w});
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        csum ^= b;
        sendByte(b, (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    sendByte(flipCsum ? ~csum : csum, 0);
`else
    if (flipCsum) $display("[TB] note: checksum byte not part of this build");
`endif
  endtask

  task automatic checkStatus(input string tag, input logic expDone, input logic expErr,
                             input logic expCpuReset, input logic expReady);
    checkOutput({tag, " done"}, 32'(done), 32'(expDone));
    checkOutput({tag, " err"}, 32'(err), 32'(expErr));
    checkOutput({tag, " cpu_reset"}, 32'(cpu_reset), 32'(expCpuReset));
    checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'(expReady));
  endtask

  task automatic checkResetValues(input string tag);
    checkStatus(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, " imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    checkOutput({tag, " imem_wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic doReset(input string tag);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Let any pending write land, then confirm nothing is left outstanding.
  task automatic drain(input string tag, input logic expDone);
    repeat (6) @(negedge clk);
    checkOutput({tag, " pending writes"}, 32'(sbq.size()), 32'd0);
    checkOutput({tag, " done sticky"}, 32'(done), 32'(expDone));
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", 32'(byte_ready), 32'd1);
    checkOutput("cpu held after reset", 32'(cpu_reset), 32'd1);

    // Two-word image, continuous stream
    @(posedge clk);
    #1;
    imageWords = '{32'hE3A05005, 32'hE2855006};
    applyStimulus(2, 0, 1'b0);
    @(negedge clk);
    checkStatus("imageA", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("imageA last write with release", 32'(imem_we), CSUM_ON ? 32'd0 : 32'd1);
    drain("imageA", 1'b1);

`ifdef BOOT_CHECKSUM_EN
    // Same image with a corrupted checksum
    doReset("reset before badsum");
    applyStimulus(2, 0, 1'b1);
    @(negedge clk);
    checkStatus("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("badsum", 1'b0);
`endif

    // Oversize count: 65 words into a 64-word memory
    doReset("reset before oversize");
    sendByte(8'h41, 0);
    sendByte(8'h00, 0);
    @(negedge clk);
    checkStatus("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("oversize ready stays low", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    drain("oversize", 1'b0);
    checkOutput("oversize err sticky", 32'(err), 32'd1);

    // Empty image
    doReset("reset before empty");
    imageWords.delete();
    applyStimulus(0, 0, 1'b0);
    @(negedge clk);
    checkStatus("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("empty", 1'b1);

    // Full-depth image: last write at address 63, no wrap to 0
    doReset("reset before full");
    imageWords.delete();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] bi = 8'(i);
      imageWords.push_back({bi ^ 8'hA5, bi + 8'h10, ~bi, bi});
    end
    applyStimulus(64, 0, 1'b0);
    @(negedge clk);
    checkStatus("full", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("full", 1'b1);

    // Three words with random idle gaps between bytes
    doReset("reset before gappy");
    imageWords = '{32'h11223344, 32'hDEADBEEF, 32'h0BADF00D};
    applyStimulus(3, 2, 1'b0);
    @(negedge clk);
    checkStatus("gappy", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("gappy", 1'b1);

    // Reset two bytes into word 1, then a fresh load from address 0
    doReset("reset before abort");
    sendByte(8'h03, 0);
    sendByte(8'h00, 0);
    sbq.push_back('{addr: ADDR_W'(0), data: 32'hCAFEF00D});
    sendByte(8'h0D, 0);
    sendByte(8'hF0, 0);
    sendByte(8'hFE, 0);
    sendByte(8'hCA, 0);
    sendByte(8'h77, 0);
    sendByte(8'h66, 0);
    @(negedge clk);
    checkOutput("abort no done", 32'(done), 32'd0);
    doReset("mid-load reset");
    checkOutput("abort first write seen", 32'(sbq.size()), 32'd0);
    imageWords = '{32'hE3A05005, 32'hE2855006};
    applyStimulus(2, 0, 1'b0);
    @(negedge clk);
    checkStatus("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("reload", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
